// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath blocks.
//   P1_W      pooled map width/height after pooling-1
//   C2_K      conv-2 kernel size
//   C2_OUT_W  conv-2 output width/height (P1_W - C2_K + 1)
//   P1_BASE   address of pixel (0,0) inside the P1 memory
//   rd_state_t  state encoding of the P1 read-window addresser
package cnn_pkg;

  localparam int P1_W     = 12;
  localparam int C2_K     = 5;
  localparam int C2_OUT_W = P1_W - C2_K + 1;
  localparam int P1_BASE  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/pix_tag_fifo.sv
// Small synchronous first-word-fall-through FIFO holding pixel + tag words.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset (pointers/count only)
//   push, wdata      write strobe and word; ignored when full
//   pop              read strobe; ignored when empty
//   rd_data          head word (valid while !empty)
//   full, empty      occupancy flags
//   count            number of stored words
module pix_tag_fifo #(
  parameter int W  = 15,
  parameter int D  = 2,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(D));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the bookkeeping does.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == PW'(D - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(D - 1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/p1_mem_read_window.sv
// Read-side addresser for the pooling-1 output memory. Streams every 5x5
// window of the 12x12 pooled map, in raster order, to the conv-2 MAC.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           pulse; begins a pass from IDLE or DONE
//   rd_en, addr     memory read strobe and address
//   rdata           memory data, valid RD_LAT cycles after rd_en
//   pix_out/valid   window pixel stream, accepted on pix_valid && pix_ready
//   pix_ready       MAC backpressure
//   win_last        beat is the last tap (ky=K-1,kx=K-1) of its window
//   out_row/col     window position (oy, ox) of the beat
//   busy, done      pass in progress / pass complete (sticky until start)
module p1_mem_read_window
  import cnn_pkg::*;
#(
  parameter int IMG_W  = P1_W,
  parameter int K      = C2_K,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BASE   = P1_BASE,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              win_last,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int TW    = 7;
  localparam int FW    = DATA_W + TW;
  localparam int CW    = $clog2(FIFO_D + 1);
  localparam int IW    = $clog2(RD_LAT + 1);
  localparam int SW    = $clog2(FIFO_D + RD_LAT + 1) + 1;

  rd_state_t         state_reg;
  logic [2:0]        oy_reg, ox_reg, ky_reg, kx_reg;
  logic [ADDR_W-1:0] win_base_reg;   // BASE + oy*IMG_W
  logic [ADDR_W-1:0] row_base_reg;   // BASE + (oy+ky)*IMG_W
  logic              vld_reg [RD_LAT];
  logic [TW-1:0]     tag_reg [RD_LAT];

  logic [IW-1:0]     in_flight;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_head;
  logic              credit_ok, last_issue, pop, drain_done, tap_last;
  logic [TW-1:0]     issue_tag;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + IW'(vld_reg[i]);
  end

  // A read is only issued when its data is guaranteed a FIFO slot on return.
  assign credit_ok  = !fifo_full && ((SW'(fifo_count) + SW'(in_flight)) < SW'(FIFO_D));
  assign rd_en      = (state_reg == ISSUE) && credit_ok;
  assign addr       = row_base_reg + ADDR_W'(ox_reg) + ADDR_W'(kx_reg);
  assign tap_last   = (ky_reg == 3'(K - 1)) && (kx_reg == 3'(K - 1));
  assign issue_tag  = {tap_last, oy_reg, ox_reg};
  assign last_issue = rd_en && tap_last && (oy_reg == 3'(OUT_W - 1)) && (ox_reg == 3'(OUT_W - 1));

  assign pix_valid  = !fifo_empty;
  assign pop        = pix_valid && pix_ready;
  // Completes on the cycle of the last pop, so done rises right after it.
  assign drain_done = (in_flight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  assign pix_out  = pix_valid ? fifo_head[FW-1:TW] : '0;
  assign win_last = pix_valid && fifo_head[6];
  assign out_row  = pix_valid ? fifo_head[5:3] : '0;
  assign out_col  = pix_valid ? fifo_head[2:0] : '0;
  assign busy     = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done     = (state_reg == DONE);

  // FSM, counter nest and row-base accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      oy_reg       <= '0;
      ox_reg       <= '0;
      ky_reg       <= '0;
      kx_reg       <= '0;
      win_base_reg <= ADDR_W'(BASE);
      row_base_reg <= ADDR_W'(BASE);
    end else begin
      case (state_reg)
        IDLE, DONE: if (start) state_reg <= ISSUE;
        ISSUE:      if (last_issue) state_reg <= DRAIN;
        DRAIN:      if (drain_done) state_reg <= DONE;
        default:    state_reg <= IDLE;
      endcase

      if (rd_en) begin
        if (kx_reg != 3'(K - 1)) begin
          kx_reg <= kx_reg + 1'b1;
        end else begin
          kx_reg <= '0;
          if (ky_reg != 3'(K - 1)) begin
            ky_reg       <= ky_reg + 1'b1;
            row_base_reg <= row_base_reg + ADDR_W'(IMG_W);
          end else begin
            ky_reg <= '0;
            if (ox_reg != 3'(OUT_W - 1)) begin
              ox_reg       <= ox_reg + 1'b1;
              row_base_reg <= win_base_reg;
            end else begin
              ox_reg <= '0;
              if (oy_reg != 3'(OUT_W - 1)) begin
                oy_reg       <= oy_reg + 1'b1;
                win_base_reg <= win_base_reg + ADDR_W'(IMG_W);
                row_base_reg <= win_base_reg + ADDR_W'(IMG_W);
              end else begin
                // Pass finished: rewind so the next pass starts at pixel (0,0).
                oy_reg       <= '0;
                win_base_reg <= ADDR_W'(BASE);
                row_base_reg <= ADDR_W'(BASE);
              end
            end
          end
        end
      end
    end
  end

  // Tag delay line: the tag arrives at the FIFO together with its rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_reg[i] <= 1'b0;
        tag_reg[i] <= '0;
      end
    end else begin
      vld_reg[0] <= rd_en;
      tag_reg[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  pix_tag_fifo #(
    .W  (FW),
    .D  (FIFO_D),
    .CW (CW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (vld_reg[RD_LAT-1]),
    .wdata   ({rdata, tag_reg[RD_LAT-1]}),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
